// File: rtl/clock_freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over a fixed
// window of clk cycles, range-checks each result and tracks a lock streak.
module clock_freq_meter #(
  parameter int unsigned GATE_CYCLES = 100,
  parameter int unsigned MIN_EDGES   = 4,
  parameter int unsigned MAX_EDGES   = 6,
  parameter int unsigned LOCK_COUNT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sig_in,
  output logic [30:0] edge_count,
  output logic        meas_valid,
  output logic        in_range,
  output logic        locked,
  output logic [3:0]  lock_run
);

  localparam logic [30:0] GATE_LAST = 31'(GATE_CYCLES - 1);
  localparam logic [30:0] MIN_L     = 31'(MIN_EDGES);
  localparam logic [30:0] MAX_L     = 31'(MAX_EDGES);
  localparam logic [3:0]  LOCK_L    = 4'(LOCK_COUNT);
  localparam logic [30:0] ACC_MAX   = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t      state, state_nxt;
  logic        s1, s2, s3;
  logic        edge_det;
  logic [30:0] gate, acc, acc_sum;
  logic        last_gate, res_in;
  logic [3:0]  run_nxt;

  assign edge_det  = s2 & ~s3;
  assign last_gate = (state == MEASURE) && en && (gate == GATE_LAST);
  // Accumulator saturates instead of wrapping.
  assign acc_sum   = (edge_det && (acc != ACC_MAX)) ? acc + 31'd1 : acc;
  assign res_in    = (acc_sum >= MIN_L) && (acc_sum <= MAX_L);
  assign run_nxt   = !res_in ? 4'd0 : (lock_run == 4'hf) ? 4'hf : lock_run + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = MEASURE;
      MEASURE: if (!en) state_nxt = IDLE;
               else if (gate == GATE_LAST) state_nxt = DONE;
      DONE:    state_nxt = en ? MEASURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      gate       <= '0;
      acc        <= '0;
      edge_count <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      locked     <= 1'b0;
      lock_run   <= '0;
    end else begin
      s1         <= sig_in;
      s2         <= s1;
      s3         <= s2;
      meas_valid <= 1'b0;
      case (state)
        MEASURE: begin
          if (!en) begin
            gate <= '0;
            acc  <= '0;
          end else begin
            gate <= gate + 31'd1;
            acc  <= acc_sum;
          end
          // Results are registered on the last gate cycle so the pulse lines up with DONE.
          if (last_gate) begin
            edge_count <= acc_sum;
            meas_valid <= 1'b1;
            in_range   <= res_in;
            lock_run   <= run_nxt;
            locked     <= res_in && (run_nxt >= LOCK_L);
          end
        end
        DONE: begin
          gate <= '0;
          acc  <= {30'd0, edge_det};
        end
        default: begin
          gate <= '0;
          acc  <= '0;
        end
      endcase
    end
  end

endmodule
